// File: rtl/cpsr_flag_ctrl.sv
// NZCV write scheduler: round-robin ALU/MSR arbitration, registered CPSR write port,
// in-flight write tracking with forwarding, and ARM condition-code evaluation.
module cpsr_flag_ctrl #(
  parameter int CPSR_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [3:0]  alu_flags,
  output logic        alu_ready,
  input  logic        msr_valid,
  input  logic [3:0]  msr_flags,
  output logic        msr_ready,
  input  logic [31:0] cpsr_out,
  output logic        cpsr_we,
  output logic [3:0]  cpsr_flagsin,
  input  logic [3:0]  cond,
  output logic [3:0]  flags_eff,
  output logic        flags_stable,
  output logic        cond_pass
);

  logic                last_msr_q, last_msr_d;
  logic [CPSR_LAT-1:0] trk_vld_q, trk_vld_d;
  logic [3:0]          trk_flags_q [CPSR_LAT];
  logic [3:0]          trk_flags_d [CPSR_LAT];
  logic                cpsr_unused;

  assign cpsr_unused = ^cpsr_out[27:0];

  // Stage 0 of the tracker doubles as the CPSR write port register.
  assign cpsr_we      = trk_vld_q[0];
  assign cpsr_flagsin = trk_flags_q[0];

  always_comb begin
    alu_ready  = !reset && alu_valid && (!msr_valid || last_msr_q);
    msr_ready  = !reset && msr_valid && (!alu_valid || !last_msr_q);
    last_msr_d = last_msr_q;
    if (alu_ready) last_msr_d = 1'b0;
    if (msr_ready) last_msr_d = 1'b1;

    trk_vld_d      = trk_vld_q;
    trk_vld_d[0]   = alu_ready || msr_ready;
    trk_flags_d[0] = alu_ready ? alu_flags :
                     msr_ready ? msr_flags : trk_flags_q[0];
    for (int i = 1; i < CPSR_LAT; i++) begin
      trk_vld_d[i]   = trk_vld_q[i-1];
      trk_flags_d[i] = trk_flags_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_msr_q <= 1'b1;
      trk_vld_q  <= '0;
      for (int i = 0; i < CPSR_LAT; i++) trk_flags_q[i] <= 4'h0;
    end else begin
      last_msr_q <= last_msr_d;
      trk_vld_q  <= trk_vld_d;
      for (int i = 0; i < CPSR_LAT; i++) trk_flags_q[i] <= trk_flags_d[i];
    end
  end

  // Youngest (lowest-index) valid entry wins over the CPSR readback.
  always_comb begin
    flags_eff = cpsr_out[31:28];
    for (int i = CPSR_LAT - 1; i >= 0; i--) begin
      if (trk_vld_q[i]) flags_eff = trk_flags_q[i];
    end
    flags_stable = ~|trk_vld_q;
  end

  logic n_f, z_f, c_f, v_f;
  assign {n_f, z_f, c_f, v_f} = flags_eff;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = !z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = !c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = !n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = !v_f;
      4'b1000: cond_pass = c_f && !z_f;
      4'b1001: cond_pass = !c_f || z_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = !z_f && (n_f == v_f);
      4'b1101: cond_pass = z_f || (n_f != v_f);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cpsr_flag_ctrl.sv
// Randomised and directed bench for cpsr_flag_ctrl against a transfer-history reference model.
module tb_cpsr_flag_ctrl;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset, alu_valid, msr_valid, alu_ready, msr_ready;
  logic [3:0]  alu_flags, msr_flags, cond, cpsr_flagsin, flags_eff;
  logic        cpsr_we, flags_stable, cond_pass;
  logic [31:0] cpsr_out;

  always #5 clk = ~clk;

  cpsr_flag_ctrl #(.CPSR_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_flags(alu_flags), .alu_ready(alu_ready),
    .msr_valid(msr_valid), .msr_flags(msr_flags), .msr_ready(msr_ready),
    .cpsr_out(cpsr_out), .cpsr_we(cpsr_we), .cpsr_flagsin(cpsr_flagsin),
    .cond(cond), .flags_eff(flags_eff), .flags_stable(flags_stable), .cond_pass(cond_pass)
  );

  // CPSR register with a registered read path: write lands LAT cycles after cpsr_we.
  logic [3:0] cpsr_fl = 4'h0;
  logic       d1_we = 1'b0;
  logic [3:0] d1_fl = 4'h0;
  always @(posedge clk) begin
    if (d1_we) cpsr_fl <= d1_fl;
    d1_we <= cpsr_we;
    d1_fl <= cpsr_flagsin;
  end
  assign cpsr_out = {cpsr_fl, 28'h1234567};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    r = z;
      3'd1:    r = cy;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = cy && !z;
      3'd5:    r = (n == v);
      3'd6:    r = !z && (n == v);
      default: r = 1'b1;
    endcase
    return c[0] ? !r : r;
  endfunction

  typedef struct { int cyc; logic [3:0] f; } wr_t;
  wr_t        hist[$];
  int         cyc_now = 0;
  logic       last_msr = 1'b1;
  logic [3:0] last_fl = 4'h0;
  logic       g_alu, g_msr;
  int         xfer_cnt = 0;
  int         we_cnt = 0;

  task automatic step(input logic rv, input logic av, input logic [3:0] af,
                      input logic mv, input logic [3:0] mf, input logic [3:0] cd);
    logic [3:0] e_eff;
    logic       e_we, e_stable;
    @(negedge clk);
    reset = rv; alu_valid = av; alu_flags = af; msr_valid = mv; msr_flags = mf; cond = cd;
    #1;
    g_alu = 1'b0; g_msr = 1'b0;
    if (!rv) begin
      if (av && mv) begin
        g_alu = last_msr; g_msr = !last_msr;
      end else begin
        g_alu = av; g_msr = mv;
      end
    end
    e_we     = (hist.size() > 0) && (hist[$].cyc == cyc_now - 1);
    e_stable = !((hist.size() > 0) && (hist[$].cyc >= cyc_now - LAT));
    e_eff    = e_stable ? cpsr_fl : hist[$].f;
    chk("alu_ready", alu_ready, g_alu);
    chk("msr_ready", msr_ready, g_msr);
    chk("cpsr_we", cpsr_we, e_we);
    chk("cpsr_flagsin", cpsr_flagsin, last_fl);
    chk("flags_eff", flags_eff, e_eff);
    chk("flags_stable", flags_stable, e_stable);
    chk("cond_pass", cond_pass, cond_ref(cd, e_eff));
    if (cpsr_we) we_cnt++;
    if (g_alu || g_msr) begin
      wr_t w;
      w.cyc = cyc_now;
      w.f   = g_alu ? af : mf;
      hist.push_back(w);
      last_fl  = w.f;
      last_msr = g_msr;
      xfer_cnt++;
    end
    if (rv) begin
      hist.delete();
      last_fl  = 4'h0;
      last_msr = 1'b1;
    end
    cyc_now++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'($urandom));
  endtask

  logic [15:0] pass_mask;
  logic [3:0]  exp_fin;
  logic        a_pend, m_pend;
  logic [3:0]  a_f, m_f;

  initial begin
    reset = 1'b1; alu_valid = 1'b0; msr_valid = 1'b0;
    alu_flags = 4'h0; msr_flags = 4'h0; cond = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_we", cpsr_we, 1'b0);
    chk("rst_flagsin", cpsr_flagsin, 4'h0);
    chk("rst_stable", flags_stable, 1'b1);
    chk("rst_eff", flags_eff, cpsr_out[31:28]);

    // Single ALU write
    step(1'b0, 1'b1, 4'b1000, 1'b0, 4'h0, 4'h0);
    chk("single_ready", alu_ready, 1'b1);
    idle(1);
    chk("single_we", cpsr_we, 1'b1);
    chk("single_flagsin", cpsr_flagsin, 4'b1000);
    chk("single_eff", flags_eff, 4'b1000);
    chk("single_busy1", flags_stable, 1'b0);
    idle(1);
    chk("single_busy2", flags_stable, 1'b0);
    idle(1);
    chk("single_stable", flags_stable, 1'b1);
    chk("single_land", flags_eff, 4'b1000);

    // Contention after a fresh reset: ALU wins first, then alternate
    step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 4'b0100, 1'b1, 4'b0010, 4'h0);
      chk("cont_alu", alu_ready, (i % 2) == 0);
      chk("cont_msr", msr_ready, (i % 2) == 1);
      if (i > 0) begin
        exp_fin = ((i - 1) % 2 == 0) ? 4'b0100 : 4'b0010;
        chk("cont_flagsin", cpsr_flagsin, exp_fin);
      end
    end
    idle(1);
    chk("cont_last", cpsr_flagsin, 4'b0010);
    idle(3);

    // Forwarding of back-to-back writes
    step(1'b0, 1'b1, 4'b0100, 1'b0, 4'h0, 4'h0);
    step(1'b0, 1'b1, 4'b0001, 1'b0, 4'h0, 4'h0);
    chk("fwd_eff1", flags_eff, 4'b0100);
    chk("fwd_eq1", cond_pass, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
    chk("fwd_eff2", flags_eff, 4'b0001);
    chk("fwd_eq2", cond_pass, 1'b0);
    for (int i = 0; i < 2; i++) begin
      idle(1);
      chk("fwd_eff34", flags_eff, 4'b0001);
    end

    // Condition sweep with N=1, V=1
    step(1'b0, 1'b1, 4'b1001, 1'b0, 4'h0, 4'h0);
    idle(3);
    pass_mask = 16'h565A;
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'(c));
      chk("sweep_eff", flags_eff, 4'b1001);
      chk("sweep_pass", cond_pass, pass_mask[c]);
    end

    // Reset while an MSR write is in flight
    step(1'b0, 1'b0, 4'h0, 1'b1, 4'b1111, 4'h0);
    chk("mid_grant", msr_ready, 1'b1);
    step(1'b1, 1'b1, 4'h3, 1'b1, 4'h5, 4'h0);
    chk("mid_rst_alu", alu_ready, 1'b0);
    chk("mid_rst_msr", msr_ready, 1'b0);
    chk("mid_rst_we", cpsr_we, 1'b1);
    idle(1);
    chk("mid_we_low", cpsr_we, 1'b0);
    chk("mid_stable", flags_stable, 1'b1);
    chk("mid_eff", flags_eff, cpsr_out[31:28]);
    idle(3);

    // Random handshake traffic
    a_pend = 1'b0; m_pend = 1'b0; a_f = 4'h0; m_f = 4'h0;
    xfer_cnt = 0; we_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!a_pend && ($urandom % 2 == 0)) begin a_pend = 1'b1; a_f = 4'($urandom); end
      if (!m_pend && ($urandom % 2 == 0)) begin m_pend = 1'b1; m_f = 4'($urandom); end
      step(1'b0, a_pend, a_f, m_pend, m_f, 4'($urandom));
      chk("one_grant", alu_ready & msr_ready, 1'b0);
      if (g_alu) a_pend = 1'b0;
      if (g_msr) m_pend = 1'b0;
    end
    idle(1);
    chk("we_vs_xfer", we_cnt, xfer_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
